// File: rtl/array_multi_read_pkg.sv
// Shared definitions for the array_multi_read sequencer: state encoding,
// packed-slice helper macros and a width helper.
`default_nettype none

`ifndef ARRAY_MULTI_READ_PKG_SV
`define ARRAY_MULTI_READ_PKG_SV

// Indexed slice of a packed vector of equal-width fields (index 0 in the LSBs).
`define AMR_SLICE(vec, i, w) vec[(i)*(w) +: (w)]

package array_multi_read_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Ceiling log2, never less than 1 so a single-entry index still has a bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`endif

`default_nettype wire

// File: rtl/array_read_match.sv
// Combinational priority match of addr[idx] against addr[0..idx-1]; reports
// the lowest matching index. Built only with ARRAY_MULTI_READ_COALESCE_EN.
`default_nettype none

`ifdef ARRAY_MULTI_READ_COALESCE_EN
module array_read_match
  import array_multi_read_pkg::*;
#(
  parameter int N_READS = 3,
  parameter int ADDR_N  = 8,
  parameter int IDX_N   = 2
) (
  input  logic [N_READS*ADDR_N-1:0] addr_i,
  input  logic [IDX_N-1:0]          idx_i,
  output logic                      hit_o,
  output logic [IDX_N-1:0]          hit_idx_o
);

  logic [ADDR_N-1:0] cur;

  always_comb begin
    cur       = `AMR_SLICE(addr_i, idx_i, ADDR_N);
    hit_o     = 1'b0;
    hit_idx_o = '0;
    // Scan downwards so the last assignment is the lowest matching index.
    for (int j = N_READS - 1; j >= 0; j--) begin
      if ((j < int'(idx_i)) && (`AMR_SLICE(addr_i, j, ADDR_N) == cur)) begin
        hit_o     = 1'b1;
        hit_idx_o = IDX_N'(j);
      end
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/array_multi_read.sv
// N-way read sequencer: takes a batch of addresses, reads them one at a time
// from a single-port array and returns all words together.
// Optional duplicate-address coalescing: ARRAY_MULTI_READ_COALESCE_EN.
`default_nettype none

module array_multi_read
  import array_multi_read_pkg::*;
#(
  parameter int N_READS = 3,
  parameter int ADDR_N  = 8,
  parameter int INT_N   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_READS*ADDR_N-1:0]  addr_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_READS*INT_N-1:0]   data_out,
  output logic                       arr_req_valid,
  input  logic                       arr_req_ready,
  output logic [ADDR_N-1:0]          arr_addr,
  input  logic                       arr_rvalid,
  input  logic [INT_N-1:0]           arr_rdata
);

  localparam int              IDX_N    = clog2_min1(N_READS);
  localparam logic [IDX_N-1:0] LAST_IDX = IDX_N'(N_READS - 1);

  state_e                    state_q, state_d;
  logic [IDX_N-1:0]          idx_q, idx_d;
  logic [N_READS*ADDR_N-1:0] addr_q, addr_d;
  logic [N_READS*INT_N-1:0]  data_q, data_d;
  logic [ADDR_N-1:0]         cur_addr;

  assign cur_addr = `AMR_SLICE(addr_q, idx_q, ADDR_N);

`ifdef ARRAY_MULTI_READ_COALESCE_EN
  logic             hit;
  logic [IDX_N-1:0] hit_idx;

  array_read_match #(
    .N_READS (N_READS),
    .ADDR_N  (ADDR_N),
    .IDX_N   (IDX_N)
  ) u_match (
    .addr_i    (addr_q),
    .idx_i     (idx_q),
    .hit_o     (hit),
    .hit_idx_o (hit_idx)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    addr_d        = addr_q;
    data_d        = data_q;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    arr_req_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          addr_d  = addr_in;
          idx_d   = '0;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
`ifdef ARRAY_MULTI_READ_COALESCE_EN
        // A repeated address copies the earlier word instead of re-reading it.
        if (hit) begin
          `AMR_SLICE(data_d, idx_q, INT_N) = `AMR_SLICE(data_q, hit_idx, INT_N);
          if (idx_q == LAST_IDX) state_d = ST_DONE;
          else                   idx_d   = idx_q + 1'b1;
        end else
`endif
        begin
          arr_req_valid = 1'b1;
          if (arr_req_ready) state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (arr_rvalid) begin
          `AMR_SLICE(data_d, idx_q, INT_N) = arr_rdata;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Address is forced to zero outside ISSUE so the bus is quiet when idle.
  assign arr_addr = (state_q == ST_ISSUE) ? cur_addr : '0;
  assign data_out = data_q;

endmodule

`default_nettype wire

// File: tb/tb_array_multi_read.sv
// Directed bench for array_multi_read: N=3 main instance plus N=1 and
// N=8/INT_N=16 instances, each with a simple array model returning addr+0x10.
`default_nettype none

module tb_array_multi_read;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // ---------------- N_READS=3 instance ----------------
  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
  logic [23:0] a_addr_in = '0, a_data;
  logic        a_req_valid, a_req_ready, a_rvalid;
  logic [7:0]  a_addr, a_rdata;
  logic        a_mrv = 1'b0, a_inj = 1'b0, a_arm = 1'b0, a_pv = 1'b0;
  logic [7:0]  a_mrd = '0, a_inj_d = '0, a_pa = '0;
  int          a_reqs = 0, a_stalls = 0, a_viol = 0, a_s0 = 0;

  array_multi_read #(.N_READS(3), .ADDR_N(8), .INT_N(8)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .addr_in(a_addr_in),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .data_out(a_data),
    .arr_req_valid(a_req_valid), .arr_req_ready(a_req_ready), .arr_addr(a_addr),
    .arr_rvalid(a_rvalid), .arr_rdata(a_rdata)
  );

  // Optional 4-cycle stall on the request to address 2.
  assign a_req_ready = !(a_arm && a_req_valid && (a_addr == 8'd2) && ((a_stalls - a_s0) < 4));
  assign a_rvalid    = a_mrv | a_inj;
  assign a_rdata     = a_inj ? a_inj_d : a_mrd;

  always @(posedge clk) begin
    a_mrv <= a_req_valid && a_req_ready;
    a_mrd <= a_addr + 8'h10;
    if (a_req_valid && a_req_ready)  a_reqs   <= a_reqs + 1;
    if (a_req_valid && !a_req_ready) a_stalls <= a_stalls + 1;
    if (a_pv && (!a_req_valid || a_addr != a_pa)) a_viol <= a_viol + 1;
    a_pv <= a_req_valid && !a_req_ready;
    a_pa <= a_addr;
  end

  // ---------------- N_READS=1 instance ----------------
  logic       b1_in_valid = 1'b0, b1_in_ready, b1_out_valid, b1_req_valid, b1_mrv = 1'b0;
  logic [7:0] b1_addr_in = '0, b1_data, b1_addr, b1_mrd = '0;

  array_multi_read #(.N_READS(1), .ADDR_N(8), .INT_N(8)) dut_b1 (
    .clk(clk), .rst(rst),
    .in_valid(b1_in_valid), .in_ready(b1_in_ready), .addr_in(b1_addr_in),
    .out_valid(b1_out_valid), .out_ready(1'b1), .data_out(b1_data),
    .arr_req_valid(b1_req_valid), .arr_req_ready(1'b1), .arr_addr(b1_addr),
    .arr_rvalid(b1_mrv), .arr_rdata(b1_mrd)
  );

  always @(posedge clk) begin
    b1_mrv <= b1_req_valid;
    b1_mrd <= b1_addr + 8'h10;
  end

  // ---------------- N_READS=8, INT_N=16 instance ----------------
  logic         b8_in_valid = 1'b0, b8_in_ready, b8_out_valid, b8_req_valid, b8_mrv = 1'b0;
  logic [63:0]  b8_addr_in = '0;
  logic [127:0] b8_data;
  logic [7:0]   b8_addr;
  logic [15:0]  b8_mrd = '0;

  array_multi_read #(.N_READS(8), .ADDR_N(8), .INT_N(16)) dut_b8 (
    .clk(clk), .rst(rst),
    .in_valid(b8_in_valid), .in_ready(b8_in_ready), .addr_in(b8_addr_in),
    .out_valid(b8_out_valid), .out_ready(1'b1), .data_out(b8_data),
    .arr_req_valid(b8_req_valid), .arr_req_ready(1'b1), .arr_addr(b8_addr),
    .arr_rvalid(b8_mrv), .arr_rdata(b8_mrd)
  );

  always @(posedge clk) begin
    b8_mrv <= b8_req_valid;
    b8_mrd <= {8'h00, b8_addr} + 16'h0010;
  end

  // Accept one batch on dut_a and count edges until out_valid.
  task automatic a_run(input logic [23:0] addrs, output int lat);
    chk("a_in_ready_before", a_in_ready, 1'b1);
    a_in_valid = 1'b1;
    a_addr_in  = addrs;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 200) chk("a_timeout", 1'b1, 1'b0);
  endtask

  int lat, r0;

  initial begin
    // Reset values
    #1;
    chk("rst_in_ready", a_in_ready, 1'b1);
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_req_valid", a_req_valid, 1'b0);
    chk("rst_arr_addr", a_addr, 8'h00);
    chk("rst_data_out", a_data, 24'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Basic
    r0 = a_reqs;
    a_run(24'h030201, lat);
    chk("basic_lat", lat, 6);
    chk("basic_data", a_data, 24'h131211);
    chk("basic_reqs", a_reqs - r0, 3);
    @(posedge clk); #1;
    chk("basic_idle", a_in_ready, 1'b1);

    // Array backpressure on second request
    a_arm = 1'b1; a_s0 = a_stalls; r0 = a_reqs;
    a_run(24'h030201, lat);
    a_arm = 1'b0;
    chk("bp_lat", lat, 10);
    chk("bp_data", a_data, 24'h131211);
    chk("bp_reqs", a_reqs - r0, 3);
    chk("bp_stalls", a_stalls - a_s0, 4);
    chk("bp_stable", a_viol, 0);
    @(posedge clk); #1;

    // Output backpressure
    a_out_ready = 1'b0;
    a_run(24'h030201, lat);
    chk("obp_lat", lat, 6);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("obp_out_valid", a_out_valid, 1'b1);
      chk("obp_data", a_data, 24'h131211);
      chk("obp_in_ready", a_in_ready, 1'b0);
    end
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("obp_out_valid_drop", a_out_valid, 1'b0);
    chk("obp_in_ready_rise", a_in_ready, 1'b1);

    // Duplicate addresses 5,5,7
    r0 = a_reqs;
    a_run(24'h070505, lat);
    chk("co_data", a_data, 24'h171515);
`ifdef ARRAY_MULTI_READ_COALESCE_EN
    chk("co_reqs", a_reqs - r0, 2);
    chk("co_lat", lat, 5);
`else
    chk("co_reqs", a_reqs - r0, 3);
    chk("co_lat", lat, 6);
`endif
    @(posedge clk); #1;

    // Reset while waiting for a response, then a stray response
    a_in_valid = 1'b1;
    a_addr_in  = 24'h060504;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_in_wait", a_req_valid, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", a_in_ready, 1'b1);
    chk("mid_rst_out_valid", a_out_valid, 1'b0);
    chk("mid_rst_arr_addr", a_addr, 8'h00);
    chk("mid_rst_data", a_data, 24'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    a_inj = 1'b1; a_inj_d = 8'hAA;
    @(posedge clk); #1;
    a_inj = 1'b0;
    chk("late_rv_data", a_data, 24'h0);
    chk("late_rv_out_valid", a_out_valid, 1'b0);
    chk("late_rv_req_valid", a_req_valid, 1'b0);
    a_run(24'h070809, lat);
    chk("post_rst_data", a_data, 24'h171819);
    chk("post_rst_lat", lat, 6);
    @(posedge clk); #1;

    // N_READS=1
    b1_in_valid = 1'b1; b1_addr_in = 8'h33;
    @(posedge clk); #1;
    b1_in_valid = 1'b0;
    lat = 0;
    while (!b1_out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("n1_lat", lat, 2);
    chk("n1_data", b1_data, 8'h43);
    @(posedge clk); #1;

    // N_READS=8, INT_N=16
    b8_in_valid = 1'b1; b8_addr_in = 64'h0706050403020100;
    @(posedge clk); #1;
    b8_in_valid = 1'b0;
    lat = 0;
    while (!b8_out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("n8_lat", lat, 16);
    chk("n8_data", b8_data, 128'h0017_0016_0015_0014_0013_0012_0011_0010);
    @(posedge clk); #1;
    chk("n8_idle", b8_in_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
